// File: rtl/repeated_sub_divider.sv
// Sequential unsigned divider: quotient and remainder by repeated subtraction.
// A small IDLE/SUB/DONE controller steps a working remainder, divisor copy and quotient counter.
module repeated_sub_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Handshake: start is accepted only in IDLE, where dividend/divisor are captured on that
  // edge; done is a single-cycle pulse in DONE, and results stay stable until the next DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            a_d     = dividend;
            b_d     = divisor;
            cnt_d   = '0;
            state_d = S_SUB;
          end
        end
      end
      S_SUB: begin
        // Count can never exceed the dividend, so no wrap guard is needed.
        if (a_q >= b_q) begin
          a_d   = a_q - b_q;
          cnt_d = cnt_q + 1'b1;
        end else begin
          quot_d  = cnt_q;
          rem_d   = a_q;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Bench for repeated_sub_divider: directed vector table, multi-cycle corner sequences,
// and random operations checked against plain-arithmetic division.
module tb_repeated_sub_divider;
  localparam int W = 16;
  localparam int MAX_CYC = 70000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad = 0;

  repeated_sub_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation; inject=1 pulses a second start with other operands mid-SUB.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int elat, input bit inject);
    logic [W-1:0] pq, pr;
    logic pdz, held_ok, busy_ok;
    int lat;
    @(negedge clk);
    pq = quotient; pr = remainder; pdz = div_by_zero;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat = 0; held_ok = 1'b1; busy_ok = 1'b1;
    while (!done && lat < MAX_CYC) begin
      if (!busy) busy_ok = 1'b0;
      if (quotient !== pq || remainder !== pr || div_by_zero !== pdz) held_ok = 1'b0;
      if (inject && lat == 3) begin start = 1'b1; dividend = 8; divisor = 2; end
      if (inject && lat == 4) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".done_seen"}, done, 1);
    if (!done) return;
    if (!busy) busy_ok = 1'b0;
    check({name, ".latency"}, lat, elat);
    check({name, ".quotient"}, quotient, eq);
    check({name, ".remainder"}, remainder, er);
    check({name, ".div_by_zero"}, div_by_zero, edz);
    check({name, ".busy_held"}, busy_ok, 1);
    check({name, ".prior_result_held"}, held_ok, 1);
    @(posedge clk); #1;
    check({name, ".done_one_cycle"}, done, 0);
    check({name, ".idle_after"}, busy, 0);
    check({name, ".result_kept"}, {quotient, remainder}, {eq, er});
  endtask

  // Reference: ordinary division; latency is quotient+1 SUB cycles, or 0 for divide-by-zero.
  task automatic run_model(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = int'(a); bi = int'(b);
    if (bi == 0) run_op(name, a, b, '1, a, 1'b1, 0, 1'b0);
    else run_op(name, a, b, W'(ai / bi), W'(ai % bi), 1'b0, ai / bi + 1, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    vecs.push_back('{a: 100,   b: 7,     exp_q: 14,      exp_r: 2,    exp_dz: 0, exp_lat: 15});
    vecs.push_back('{a: 5,     b: 9,     exp_q: 0,       exp_r: 5,    exp_dz: 0, exp_lat: 1});
    vecs.push_back('{a: 0,     b: 3,     exp_q: 0,       exp_r: 0,    exp_dz: 0, exp_lat: 1});
    vecs.push_back('{a: 1234,  b: 0,     exp_q: 16'hFFFF, exp_r: 1234, exp_dz: 1, exp_lat: 0});
    vecs.push_back('{a: 9,     b: 3,     exp_q: 3,       exp_r: 0,    exp_dz: 0, exp_lat: 4});
    vecs.push_back('{a: 0,     b: 0,     exp_q: 16'hFFFF, exp_r: 0,    exp_dz: 1, exp_lat: 0});
    vecs.push_back('{a: 65535, b: 65535, exp_q: 1,       exp_r: 0,    exp_dz: 0, exp_lat: 2});
    vecs.push_back('{a: 65535, b: 1,     exp_q: 65535,   exp_r: 0,    exp_dz: 0, exp_lat: 65536});
    vecs.push_back('{a: 1000,  b: 999,   exp_q: 1,       exp_r: 1,    exp_dz: 0, exp_lat: 2});

    // Reset block
    #2 rst_n = 1'b0;
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.outputs", {quotient, remainder, div_by_zero}, 0);
    check("reset.state", state_dbg, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r,
             vecs[i].exp_dz, vecs[i].exp_lat, 1'b0);

    // start while busy is ignored
    run_op("ignored_start", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 11, 1'b1);

    // asynchronous reset mid-SUB
    @(negedge clk);
    start = 1'b1; dividend = 200; divisor = 3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.outputs", {quotient, remainder, div_by_zero}, 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort.no_done", dones, 0);
    run_op("after_abort", 16'd7, 16'd2, 16'd3, 16'd1, 1'b0, 4, 1'b0);

    // start held high: a new op every quotient+3 cycles (20/6: period 6)
    @(negedge clk);
    start = 1'b1; dividend = 20; divisor = 6;
    dones = 0;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        check("held.result", {quotient, remainder}, {16'd3, 16'd2});
      end
    end
    check("held.done_count", dones, 2);
    start = 1'b0;
    repeat (8) @(posedge clk);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) rb = '0;
      else begin
        rb = W'($urandom_range(1, 65535));
        if (int'(ra) / int'(rb) > 200) rb = W'(int'(ra) / 200 + 1);
      end
      run_model($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
